pipeline_control: RTL and testbench

- Run-control and hazard sequencer for the 5-stage PCPU pipeline (IF/ID/EX/MEM/WB, 8-bit i_addr, 16-bit instructions).
- Owns the run state (idle/run/drain/halted) and drives the PC update controls: PC write, PC load and PC load value.
- Drives pipeline flush after taken JUMP/JMPR/Bxx, the HALT drain sequence, and an optional load-use stall.
- Sits between the decode/branch-resolve logic and the IF stage and pipeline registers.

---
 rtl/pipeline_control.sv | 160 ++++++++++++++++
 tb/tb_pipeline_control.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Run-control and hazard sequencer for the PCPU 5-stage pipeline: run state, PC update,
// flush/drain sequencing. Optional load-use stall is enabled by PCPU_LOAD_USE_STALL_EN.
module pipeline_control #(
  parameter int ADDR_W       = 8,
  parameter int FLUSH_SLOTS  = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_id_halt,
  input  logic              i_br_taken,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_ex_load,
  input  logic [2:0]        i_ex_rd,
  input  logic [2:0]        i_id_rs_a,
  input  logic [2:0]        i_id_rs_b,
  input  logic              i_id_use_a,
  input  logic              i_id_use_b,
  output logic              o_pc_we,
  output logic              o_pc_load,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_stall,
  output logic              o_bubble,
  output logic              o_flush,
  output logic              o_running,
  output logic              o_halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [2:0] C_FLUSH_INIT = 3'(FLUSH_SLOTS - 1);
  localparam logic [2:0] C_DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_nxt;
  logic [2:0] r_drain_cnt;
  logic [2:0] w_drain_nxt;
  logic       w_act;
  logic       w_hazard;

  // Reset overrides every same-cycle request, so it also masks the combinational outputs.
  assign w_act = i_enable & ~i_reset;

`ifdef PCPU_LOAD_USE_STALL_EN
  logic r_stall_q;
  logic w_stall_q_nxt;

  // r_stall_q limits the stall to one cycle; by then the load has moved past EX.
  assign w_hazard = i_ex_load & ~r_stall_q &
                    ((i_id_use_a & (i_id_rs_a == i_ex_rd)) |
                     (i_id_use_b & (i_id_rs_b == i_ex_rd)));
  assign w_stall_q_nxt = w_act ? o_stall : r_stall_q;
`else
  logic w_unused_hazard;

  assign w_hazard        = 1'b0;
  assign w_unused_hazard = ^{i_ex_load, i_ex_rd, i_id_rs_a, i_id_rs_b, i_id_use_a, i_id_use_b};
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= 3'd0;
      r_drain_cnt <= 3'd0;
`ifdef PCPU_LOAD_USE_STALL_EN
      r_stall_q   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_drain_cnt <= w_drain_nxt;
`ifdef PCPU_LOAD_USE_STALL_EN
      r_stall_q   <= w_stall_q_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush_nxt = r_flush_cnt;
    w_drain_nxt = r_drain_cnt;
    o_pc_we     = 1'b0;
    o_pc_load   = 1'b0;
    o_pc_next   = '0;
    o_stall     = 1'b0;
    o_bubble    = 1'b0;
    o_flush     = 1'b0;

    if (w_act) begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (i_start) begin
            o_pc_we     = 1'b1;
            o_pc_load   = 1'b1;
            o_flush     = 1'b1;
            w_state_nxt = S_RUN;
            w_flush_nxt = 3'd0;
            w_drain_nxt = 3'd0;
          end
        end
        S_RUN: begin
          o_pc_we = 1'b1;
          // Anything arriving during the flush window is on the wrong path.
          if (r_flush_cnt != 3'd0) begin
            o_flush     = 1'b1;
            w_flush_nxt = r_flush_cnt - 3'd1;
          end else if (i_br_taken) begin
            o_pc_load   = 1'b1;
            o_pc_next   = i_br_target;
            o_flush     = 1'b1;
            w_flush_nxt = C_FLUSH_INIT;
          end else if (w_hazard) begin
            o_pc_we  = 1'b0;
            o_stall  = 1'b1;
            o_bubble = 1'b1;
          end else if (i_id_halt) begin
            o_pc_we     = 1'b0;
            w_state_nxt = S_DRAIN;
            w_drain_nxt = C_DRAIN_INIT;
          end
        end
        S_DRAIN: begin
          if (i_br_taken) begin
            // An older branch resolved: the HALT behind it was never really executed.
            o_pc_we     = 1'b1;
            o_pc_load   = 1'b1;
            o_pc_next   = i_br_target;
            o_flush     = 1'b1;
            w_flush_nxt = C_FLUSH_INIT;
            w_drain_nxt = 3'd0;
            w_state_nxt = S_RUN;
          end else begin
            o_flush = 1'b1;
            if (r_drain_cnt == 3'd0) begin
              w_state_nxt = S_HALTED;
            end else begin
              w_drain_nxt = r_drain_cnt - 3'd1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign o_running = (r_state == S_RUN)    & ~i_reset;
  assign o_halted  = (r_state == S_HALTED) & ~i_reset;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: the driver queues hand-computed output vectors,
// a negedge monitor pops and compares them against the live outputs.
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       reset, enable, start, id_halt, br_taken;
  logic [7:0] br_target;
  logic       ex_load, id_use_a, id_use_b;
  logic [2:0] ex_rd, id_rs_a, id_rs_b;
  logic       pc_we, pc_load, stall, bubble, flush, running, halted;
  logic [7:0] pc_next;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_control #(.ADDR_W(8), .FLUSH_SLOTS(3), .DRAIN_CYCLES(3)) dut (
    .i_clock    (clk),
    .i_reset    (reset),
    .i_enable   (enable),
    .i_start    (start),
    .i_id_halt  (id_halt),
    .i_br_taken (br_taken),
    .i_br_target(br_target),
    .i_ex_load  (ex_load),
    .i_ex_rd    (ex_rd),
    .i_id_rs_a  (id_rs_a),
    .i_id_rs_b  (id_rs_b),
    .i_id_use_a (id_use_a),
    .i_id_use_b (id_use_b),
    .o_pc_we    (pc_we),
    .o_pc_load  (pc_load),
    .o_pc_next  (pc_next),
    .o_stall    (stall),
    .o_bubble   (bubble),
    .o_flush    (flush),
    .o_running  (running),
    .o_halted   (halted)
  );

  // {pc_we, pc_load, pc_next, stall, bubble, flush, running, halted}
  function automatic logic [14:0] ev(input logic we, input logic ld, input logic [7:0] nxt,
                                     input logic st, input logic bb, input logic fl,
                                     input logic run, input logic hlt);
    return {we, ld, nxt, st, bb, fl, run, hlt};
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] obs;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      obs = {pc_we, pc_load, pc_next, stall, bubble, flush, running, halted};
      n_checks++;
      if (obs !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got we/ld/next/st/bb/fl/run/hlt=%h required=%h", e.name, obs, e.exp);
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic en, input logic st,
                      input logic hl, input logic br, input logic [7:0] tg, input logic hz,
                      input logic [14:0] ex);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    enable    = en;
    start     = st;
    id_halt   = hl;
    br_taken  = br;
    br_target = tg;
    ex_load   = hz;
    ex_rd     = 3'd1;
    id_rs_a   = hz ? 3'd1 : 3'd4;
    id_use_a  = hz;
    id_rs_b   = 3'd2;
    id_use_b  = 1'b0;
    e.name    = nm;
    e.exp     = ex;
    sb_q.push_back(e);
  endtask

  initial begin
    logic [14:0] haz1;
    logic [14:0] run_we;
    reset = 1'b1; enable = 1'b1; start = 1'b0; id_halt = 1'b0; br_taken = 1'b0;
    br_target = 8'h00; ex_load = 1'b0; ex_rd = 3'd0; id_rs_a = 3'd0; id_rs_b = 3'd0;
    id_use_a = 1'b0; id_use_b = 1'b0;
    run_we = ev(1, 0, 8'h00, 0, 0, 0, 1, 0);
`ifdef PCPU_LOAD_USE_STALL_EN
    haz1 = ev(0, 0, 8'h00, 1, 1, 0, 1, 0);
`else
    haz1 = run_we;
`endif

    //    name            rst en st hl br target hz  expected
    step("reset_wins",    1, 1, 1, 0, 1, 8'h2a, 0, ev(0, 0, 8'h00, 0, 0, 0, 0, 0));
    step("idle",          0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 0, 0));
    step("start",         0, 1, 1, 0, 0, 8'h77, 0, ev(1, 1, 8'h00, 0, 0, 1, 0, 0));
    step("run_first",     0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("br_2a",         0, 1, 0, 0, 1, 8'h2a, 0, ev(1, 1, 8'h2a, 0, 0, 1, 1, 0));
    step("flush_w2",      0, 1, 0, 0, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("flush_w3_br",   0, 1, 0, 0, 1, 8'h55, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("flush_done",    0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("hazard_1",      0, 1, 0, 0, 0, 8'h00, 1, haz1);
    step("hazard_2",      0, 1, 0, 0, 0, 8'h00, 1, run_we);
    step("halt_seen",     0, 1, 0, 1, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("drain_1",       0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 1, 0, 0));
    step("drain_2_start", 0, 1, 1, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 1, 0, 0));
    step("drain_3",       0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 1, 0, 0));
    step("halted",        0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 0, 1));
    step("restart",       0, 1, 1, 0, 0, 8'h00, 0, ev(1, 1, 8'h00, 0, 0, 1, 0, 1));
    step("rerun",         0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("br_10",         0, 1, 0, 0, 1, 8'h10, 0, ev(1, 1, 8'h10, 0, 0, 1, 1, 0));
    step("halt_in_fl_1",  0, 1, 0, 1, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("halt_in_fl_2",  0, 1, 0, 1, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("no_drain",      0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("halt_again",    0, 1, 0, 1, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("drain_a1",      0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 1, 0, 0));
    step("drain_br_0c",   0, 1, 0, 0, 1, 8'h0c, 0, ev(1, 1, 8'h0c, 0, 0, 1, 0, 0));
    step("cancel_fl_2",   0, 1, 0, 0, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("cancel_fl_3",   0, 1, 0, 0, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("cancel_done",   0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("br_33",         0, 1, 0, 0, 1, 8'h33, 0, ev(1, 1, 8'h33, 0, 0, 1, 1, 0));
    step("freeze_1",      0, 0, 0, 0, 1, 8'h44, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("freeze_2",      0, 0, 0, 1, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("freeze_3",      0, 0, 1, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("freeze_4",      0, 0, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 1, 0));
    step("thaw_fl_2",     0, 1, 0, 0, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("thaw_fl_3",     0, 1, 0, 0, 0, 8'h00, 0, ev(1, 0, 8'h00, 0, 0, 1, 1, 0));
    step("thaw_done",     0, 1, 0, 0, 0, 8'h00, 0, run_we);
    step("reset_run",     1, 1, 0, 0, 1, 8'h20, 0, ev(0, 0, 8'h00, 0, 0, 0, 0, 0));
    step("idle_after",    0, 1, 0, 0, 0, 8'h00, 0, ev(0, 0, 8'h00, 0, 0, 0, 0, 0));

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
